dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_if.sv | 26 ++
 rtl/dmem_ram.sv | 35 +++
 rtl/dmem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory controller.
//   size_e      - access size encoding carried on req_size
//   state_e     - controller FSM states
//   size_strobe - byte-lane strobe for a given access size and byte offset
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Reserved size yields an empty strobe so nothing can be written by accident.
  function automatic logic [3:0] size_strobe(size_e size, logic [1:0] offset);
    logic [3:0] strb;
    case (size)
      SZ_B:    strb = 4'b0001 << offset;
      SZ_H:    strb = 4'b0011 << offset;
      SZ_W:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bus between a load/store unit and dmem_ctrl.
//   master - drives requests and resp_ready (requester side)
//   slave  - drives req_ready and the response (controller side)
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: word-organised byte-lane memory.
//   clk          - write clock
//   we/waddr     - write enable and word address
//   wstrb/wdata  - per-byte write strobe and lane-aligned write data
//   raddr/rdata  - combinational word read
// Contents are deliberately not reset.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wstrb,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem_r [DEPTH_WORDS];

  // Byte-lane write: only strobed lanes are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem_r[waddr][b] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding load/store controller over dmem_ram.
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - dmem_if slave: request (valid/ready/we/addr/size/unsigned/wdata)
//           and response (valid/ready/rdata/err)
// Stores commit and loads read on the acceptance edge; the response is
// presented READ_LAT cycles later and held until consumed. Only DATA_W=32
// is supported.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 2
) (
  input  logic clk,
  input  logic reset,
  dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e              state_r;
  logic [2:0]          cnt_r;
  logic [DATA_W-1:0]   hold_rdata_r;
  logic                hold_err_r;
  logic                req_ready_r;
  logic                resp_valid_r;
  logic [DATA_W-1:0]   resp_rdata_r;
  logic                resp_err_r;

  size_e               size_s;
  logic [1:0]          offset_s;
  logic                misalign_s;
  logic                range_s;
  logic                err_s;
  logic                ram_we_s;
  logic [3:0]          strb_s;
  logic [DATA_W-1:0]   wdata_s;
  logic [DATA_W-1:0]   rword_s;
  logic [DATA_W-1:0]   shifted_s;
  logic [DATA_W-1:0]   load_data_s;
  logic [DATA_W-1:0]   resp_data_s;

  assign size_s    = size_e'(bus.req_size);
  assign offset_s  = bus.req_addr[1:0];
  assign range_s   = (bus.req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign err_s     = misalign_s || range_s || (size_s == SZ_RSV);
  assign strb_s    = size_strobe(size_s, offset_s);
  assign wdata_s   = bus.req_wdata << {offset_s, 3'b000};
  assign shifted_s = rword_s >> {offset_s, 3'b000};
  // req_ready is high only in IDLE, so it doubles as the acceptance qualifier.
  assign ram_we_s  = bus.req_valid && req_ready_r && bus.req_we && !err_s;

  // Alignment check for the requested size.
  always_comb begin
    misalign_s = 1'b0;
    case (size_s)
      SZ_H:    misalign_s = offset_s[0];
      SZ_W:    misalign_s = (offset_s != 2'b00);
      default: misalign_s = 1'b0;
    endcase
  end

  // Load data: lane-shifted word masked to size, then sign/zero extended.
  always_comb begin
    load_data_s = 32'h0000_0000;
    case (size_s)
      SZ_B: begin
        if (bus.req_unsigned) begin
          load_data_s = {24'h00_0000, shifted_s[7:0]};
        end else begin
          load_data_s = {{24{shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      SZ_H: begin
        if (bus.req_unsigned) begin
          load_data_s = {16'h0000, shifted_s[15:0]};
        end else begin
          load_data_s = {{16{shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      SZ_W:    load_data_s = shifted_s;
      default: load_data_s = 32'h0000_0000;
    endcase
  end

  // Stores and errors always answer with zero data.
  always_comb begin
    resp_data_s = 32'h0000_0000;
    if (err_s || bus.req_we) begin
      resp_data_s = 32'h0000_0000;
    end else begin
      resp_data_s = load_data_s;
    end
  end

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (bus.req_addr[AW+1:2]),
    .wstrb (strb_s),
    .wdata (wdata_s),
    .raddr (bus.req_addr[AW+1:2]),
    .rdata (rword_s)
  );

  // Controller FSM with registered handshake and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= 3'd0;
      hold_rdata_r <= 32'h0000_0000;
      hold_err_r   <= 1'b0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_r <= 1'b0;
            if (READ_LAT == 1) begin
              state_r      <= RESP;
              cnt_r        <= 3'd0;
              resp_valid_r <= 1'b1;
              resp_rdata_r <= resp_data_s;
              resp_err_r   <= err_s;
            end else begin
              state_r      <= WAIT;
              cnt_r        <= 3'(READ_LAT - 1);
              hold_rdata_r <= resp_data_s;
              hold_err_r   <= err_s;
            end
          end
        end
        WAIT: begin
          // The decrement that takes the counter to zero also raises resp_valid,
          // giving exactly READ_LAT cycles from acceptance.
          if (cnt_r <= 3'd1) begin
            state_r      <= RESP;
            cnt_r        <= 3'd0;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= hold_rdata_r;
            resp_err_r   <= hold_err_r;
            hold_rdata_r <= 32'h0000_0000;
            hold_err_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            resp_err_r   <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          cnt_r        <= 3'd0;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_rdata_r <= 32'h0000_0000;
          resp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: table-driven bench for dmem_ctrl with a response scoreboard,
// plus hand-written reset and back-pressure sequences.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int READ_LAT    = 2;
  localparam int DEPTH_WORDS = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_if bus();

  dmem_ctrl #(.DATA_W(32), .DEPTH_WORDS(DEPTH_WORDS), .READ_LAT(READ_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err, input int hold);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.hold = hold;
    return v;
  endfunction

  // One full transaction; while the request is in flight the request inputs are
  // scrambled and req_valid stays high, which the controller must ignore.
  task automatic do_req(input vec_t v, input string tag);
    exp_t        e;
    int          lat;
    bit          seen;
    logic [31:0] snap_d;
    logic        snap_e;
    @(negedge clk);
    check({tag, " req_ready idle"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_we       = v.we;
    bus.req_addr     = v.addr;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_wdata    = v.wdata;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_we       = ~v.we;
    bus.req_addr     = v.addr ^ 32'h0000_0004;
    bus.req_size     = 2'b10;
    bus.req_unsigned = ~v.uns;
    bus.req_wdata    = ~v.wdata;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) begin
        seen = 1'b1;
      end else begin
        check({tag, " req_ready wait"}, {31'd0, bus.req_ready}, 32'd0);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no resp_valid expected one within 20 cycles", tag);
      bus.req_valid = 1'b0;
      void'(sb_q.pop_front());
      return;
    end
    check({tag, " latency"}, 32'(lat), 32'(READ_LAT));
    check({tag, " req_ready resp"}, {31'd0, bus.req_ready}, 32'd0);
    snap_d = bus.resp_rdata;
    snap_e = bus.resp_err;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, {31'd0, bus.resp_valid}, 32'd1);
      check({tag, " hold rdata"}, bus.resp_rdata, snap_d);
      check({tag, " hold err"}, {31'd0, bus.resp_err}, {31'd0, snap_e});
      check({tag, " hold req_ready"}, {31'd0, bus.req_ready}, 32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    e = sb_q.pop_front();
    check({tag, " rdata"}, snap_d, e.rdata);
    check({tag, " err"}, {31'd0, snap_e}, {31'd0, e.err});
    @(negedge clk);
    check({tag, " req_ready after"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, " resp_valid after"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'h0;
    bus.resp_ready   = 1'b0;
    reset            = 1'b1;

    // Vectors: we, addr, size, unsigned, wdata, expected rdata, expected err, hold cycles.
    vecs.push_back(mk(1'b1, 32'h4,    2'b10, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h4,    2'b10, 1'b0, 32'h0,         32'h1234_5678, 1'b0, 5));
    vecs.push_back(mk(1'b1, 32'h5,    2'b00, 1'b0, 32'h0000_00AB, 32'h0000_0000, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h5,    2'b00, 1'b0, 32'h0,         32'hFFFF_FFAB, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h5,    2'b00, 1'b1, 32'h0,         32'h0000_00AB, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h4,    2'b10, 1'b0, 32'h0,         32'h1234_AB78, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'h0,    2'b10, 1'b0, 32'h1122_3344, 32'h0000_0000, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h3,    2'b01, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 0));
    vecs.push_back(mk(1'b0, 32'h0,    2'b10, 1'b0, 32'h0,         32'h1122_3344, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'h1000, 2'b10, 1'b0, 32'h0000_0055, 32'h0000_0000, 1'b1, 0));
    vecs.push_back(mk(1'b0, 32'h0,    2'b10, 1'b0, 32'h0,         32'h1122_3344, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'h6,    2'b01, 1'b0, 32'h0000_8001, 32'h0000_0000, 1'b0, 2));
    vecs.push_back(mk(1'b0, 32'h6,    2'b01, 1'b0, 32'h0,         32'hFFFF_8001, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h6,    2'b01, 1'b1, 32'h0,         32'h0000_8001, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h4,    2'b10, 1'b0, 32'h0,         32'h8001_AB78, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h7,    2'b00, 1'b0, 32'h0,         32'hFFFF_FF80, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h0,    2'b11, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 0));
    vecs.push_back(mk(1'b0, 32'h2,    2'b10, 1'b0, 32'h0,         32'h0000_0000, 1'b1, 0));
    vecs.push_back(mk(1'b1, 32'h0,    2'b00, 1'b0, 32'hFFFF_FF12, 32'h0000_0000, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'h0,    2'b10, 1'b0, 32'h0,         32'h1122_3312, 1'b0, 0));
    vecs.push_back(mk(1'b1, 32'hFFC,  2'b10, 1'b0, 32'hA5A5_5A5A, 32'h0000_0000, 1'b0, 0));
    vecs.push_back(mk(1'b0, 32'hFFC,  2'b10, 1'b0, 32'h0,         32'hA5A5_5A5A, 1'b0, 1));
    vecs.push_back(mk(1'b1, 32'h8,    2'b10, 1'b0, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 0));

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("reset resp_rdata", bus.resp_rdata, 32'h0);
    check("reset resp_err", {31'd0, bus.resp_err}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during WAIT of a load: the response must never appear.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'h8;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_wait in wait", {31'd0, bus.req_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("rst_wait async req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_wait async resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_wait dropped resp", {31'd0, bus.resp_valid}, 32'd0);
      check("rst_wait req_ready", {31'd0, bus.req_ready}, 32'd1);
    end
    do_req(mk(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 0), "post_reset");

    check("scoreboard empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1);
  end

endmodule
